// File: rtl/frv_rng_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frv_rng_arbiter: shares one external RNG port between CPU requests and a |
// | periodic background health poll.                          Revision: 1.0  |
// +--------------------------------------------------------------------------+
module frv_rng_arbiter #(
  parameter int unsigned POLL_PERIOD         = 1024,
  parameter bit          POLL_EN             = 1'b1,
  parameter logic [2:0]  RNG_IF_INIT_HEALTHY = 3'b001
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_flush,
  input  logic        cpu_req_valid,
  input  logic [2:0]  cpu_req_op,
  input  logic [31:0] cpu_req_data,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [2:0]  cpu_rsp_status,
  output logic [31:0] cpu_rsp_data,
  input  logic        cpu_rsp_ready,
  output logic        rng_req_valid,
  output logic [2:0]  rng_req_op,
  output logic [31:0] rng_req_data,
  input  logic        rng_req_ready,
  input  logic        rng_rsp_valid,
  input  logic [2:0]  rng_rsp_status,
  input  logic [31:0] rng_rsp_data,
  output logic        rng_rsp_ready,
  output logic        rng_health_ok
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_REQ    = 2'd1;
  localparam logic [1:0]  ST_RSP    = 2'd2;
  localparam logic        OWN_CPU   = 1'b0;
  localparam logic        OWN_POLL  = 1'b1;
  localparam logic [2:0]  OP_TEST   = 3'b100;
  localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        owner;
  logic        last_owner;
  logic [15:0] poll_cnt;
  logic        poll_pending;
  logic        drop;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic        health_ok;
  logic        idle;
  logic        grant_cpu;
  logic        grant_poll;
  logic        rsp_fire;

  // Round-robin: on a conflict the requester that did not win last time gets it.
  assign idle       = (state == ST_IDLE);
  assign grant_cpu  = idle && cpu_req_valid && (!poll_pending || (last_owner == OWN_POLL));
  assign grant_poll = idle && poll_pending && (!cpu_req_valid || (last_owner == OWN_CPU));
  assign rsp_fire   = (state == ST_RSP) && rng_rsp_valid && rng_rsp_ready;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_cpu || grant_poll) state_nxt = ST_REQ;
      ST_REQ:  if (rng_req_ready) state_nxt = ST_RSP;
      ST_RSP:  if (rsp_fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held, even mid-transaction.
  always_comb begin
    cpu_req_ready = 1'b0;
    rng_req_valid = 1'b0;
    rng_rsp_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    if (!g_reset) begin
      case (state)
        ST_IDLE: cpu_req_ready = grant_cpu;
        ST_REQ:  rng_req_valid = 1'b1;
        ST_RSP: begin
          if ((owner == OWN_POLL) || drop || cpu_flush) begin
            rng_rsp_ready = 1'b1;
          end else begin
            rng_rsp_ready = cpu_rsp_ready;
            cpu_rsp_valid = rng_rsp_valid;
          end
        end
        default: ;
      endcase
    end
  end

  assign rng_req_op     = req_op;
  assign rng_req_data   = req_data;
  assign cpu_rsp_status = rng_rsp_status;
  assign cpu_rsp_data   = rng_rsp_data;
  assign rng_health_ok  = health_ok;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      owner      <= OWN_CPU;
      last_owner <= OWN_POLL;
      req_op     <= '0;
      req_data   <= '0;
      drop       <= 1'b0;
      health_ok  <= 1'b0;
    end else begin
      if (grant_cpu) begin
        owner      <= OWN_CPU;
        last_owner <= OWN_CPU;
        req_op     <= cpu_req_op;
        req_data   <= cpu_req_data;
      end else if (grant_poll) begin
        owner      <= OWN_POLL;
        last_owner <= OWN_POLL;
        req_op     <= OP_TEST;
        req_data   <= '0;
      end
      if (rsp_fire) begin
        drop <= 1'b0;
      end else if (cpu_flush && (owner == OWN_CPU) && !idle) begin
        drop <= 1'b1;
      end
      // Dropped CPU test responses still refresh the health flag.
      if (rsp_fire && (req_op == OP_TEST)) begin
        health_ok <= (rng_rsp_status == RNG_IF_INIT_HEALTHY);
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else if (poll_pending) begin
      if ((state == ST_REQ) && (owner == OWN_POLL) && rng_req_ready) begin
        poll_pending <= 1'b0;
      end
    end else if (POLL_EN) begin
      if (poll_cnt == POLL_LAST) begin
        poll_pending <= 1'b1;
        poll_cnt     <= '0;
      end else begin
        poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/frv_rng_arbiter.md
FRV_RNG_ARBITER -- requirements
Module: frv_rng_arbiter

Interface
REQ-001 Parameter POLL_PERIOD, default 1024, sets the number of cycles between background health-test requests; legal range 2..65535.
REQ-002 Parameter POLL_EN, default 1, enables background health polling; 0 disables it.
REQ-003 g_clk  input  1  global clock; all state updates on its rising edge.
REQ-004 g_reset  input  1  synchronous, active-high reset.
REQ-005 cpu_flush  input  1  CPU pipeline flush; any CPU response still owed is discarded.
REQ-006 cpu_req_valid  input  1  CPU RNG request valid.
REQ-007 cpu_req_op  input  3  CPU operation {test, samp, seed}.
REQ-008 cpu_req_data  input  32  CPU seed/init data.
REQ-009 cpu_req_ready  output  1  arbiter accepts the CPU request this cycle.
REQ-010 cpu_rsp_valid  output  1  response for the CPU is valid.
REQ-011 cpu_rsp_status  output  3  RNG status returned to the CPU.
REQ-012 cpu_rsp_data  output  32  RNG data returned to the CPU.
REQ-013 cpu_rsp_ready  input  1  CPU accepts the response (pipeline progress).
REQ-014 rng_req_valid / rng_req_op[2:0] / rng_req_data[31:0]  output  request to the external RNG.
REQ-015 rng_req_ready  input  1  external RNG accepts the request.
REQ-016 rng_rsp_valid / rng_rsp_status[2:0] / rng_rsp_data[31:0]  input  response from the external RNG.
REQ-017 rng_rsp_ready  output  1  arbiter accepts the RNG response.
REQ-018 rng_health_ok  output  1  status of the last completed test response equals RNG_IF_INIT_HEALTHY.

Function
REQ-019 FSM states: IDLE, REQ (driving the RNG request), RSP (awaiting the RNG response); at most one transaction is outstanding.
REQ-020 owner register: CPU or POLL; set on grant and held until the transaction returns to IDLE.
REQ-021 Poll counter: 16 bits; increments every cycle while poll_pending=0 and POLL_EN=1.
REQ-022 Poll counter, wrap: on reaching POLL_PERIOD-1, poll_pending is set to 1 and the counter is cleared to 0.
REQ-023 poll_pending is cleared on the cycle the RNG accepts a POLL-owned request; counting resumes on the next cycle.
REQ-024 Grant occurs only in IDLE; the grant cycle registers op and data, and the FSM moves to REQ on the next cycle.
REQ-025 cpu_req_ready = 1 only on the CPU grant cycle (single-cycle pulse); it is combinational from IDLE, the arbitration result and cpu_req_valid.
REQ-026 Arbitration, both requesting in IDLE: the non-last owner wins (round-robin); last owner resets to POLL so that the CPU wins the first conflict.
REQ-027 A POLL request is issued with op 3'b100 (test) and data 0.
REQ-028 In REQ: rng_req_valid = 1 and rng_req_op/rng_req_data come from registers, stable until rng_req_ready; on acceptance the FSM moves to RSP.
REQ-029 In RSP with owner POLL: rng_rsp_ready = 1 and the response is consumed internally; cpu_rsp_valid stays 0.
REQ-030 In RSP with owner CPU, not dropped: cpu_rsp_valid = rng_rsp_valid, cpu_rsp_status/data pass through combinationally, and rng_rsp_ready = cpu_rsp_ready.
REQ-031 Drop flag: set by cpu_flush while owner is CPU in REQ or RSP.
REQ-032 While the drop flag or cpu_flush is set, rng_rsp_ready = 1 and cpu_rsp_valid = 0; a request already in REQ is still issued and its response is discarded.
REQ-033 cpu_flush in IDLE has no effect.
REQ-034 Completion: rng_rsp_valid && rng_rsp_ready returns the FSM to IDLE and clears the drop flag; the next grant is no earlier than the following cycle.
REQ-035 rng_health_ok updates on completion of any test-op response (POLL, or CPU whether or not dropped); seed and sample responses leave it unchanged.
REQ-036 rng_req_valid, cpu_rsp_valid and rng_rsp_ready are 0 in IDLE.

Reset
REQ-037 g_reset on any cycle, including mid-transaction, forces: FSM IDLE, owner CPU, last owner POLL, poll counter 0, poll_pending 0, drop 0, rng_health_ok 0, and all request registers 0.
REQ-038 During and immediately after reset, every valid/ready output is 0.

Verification
REQ-039 CPU sample: cpu_req op 3'b010, data 0xDEADBEEF; RNG ready=1, rsp data 0x12345678; cpu_rsp_ready=1 -> cpu_req_ready pulses at cycle 0, rng_req_valid at cycle 1 with data 0xDEADBEEF, cpu_rsp_data=0x12345678, FSM back in IDLE.
REQ-040 Poll: POLL_PERIOD=4, no CPU traffic -> rng_req_valid with op 3'b100 at cycle 5 after reset release; rsp status=RNG_IF_INIT_HEALTHY -> rng_health_ok=1, cpu_rsp_valid never asserted.
REQ-041 Conflict: poll_pending and cpu_req_valid together in IDLE -> CPU granted first and POLL granted next; a repeat conflict then grants CPU again.
REQ-042 Flush: cpu_flush during REQ with rng_req_ready held 0 for 3 cycles -> request still issued, response consumed with rng_rsp_ready=1, cpu_rsp_valid=0, FSM returns to IDLE.
REQ-043 Backpressure: CPU response with cpu_rsp_ready=0 for 5 cycles -> rng_rsp_ready=0 and the FSM holds RSP; completes on the cycle cpu_rsp_ready=1.
REQ-044 Reset mid-RSP -> next cycle FSM IDLE, all valid outputs 0, rng_health_ok=0, poll counter restarts from 0.
